// File: rtl/z80_bus_bridge.sv
// z80_bus_bridge
//
// Purpose:
//   Bridges Z80-style CPU bus strobes onto a multi-channel, acknowledge-based
//   memory/peripheral bus.
//   - Each CPU cycle is decoded to one of NCH chip-select channels.
//     Memory cycles use the top log2(NCH) address bits. I/O cycles go to IO_CH.
//   - WS wait states are inserted before the chip select is raised.
//   - The CPU is held in wait until the selected target acknowledges, or until
//     TIMEOUT cycles pass with no acknowledge.
//   - Interrupt-acknowledge cycles are answered locally with IACK_VECTOR.
//
// Ports:
//   i_clk, i_reset_n     clock, asynchronous active-low reset
//   i_addr, i_cpu_dat    CPU address and write data
//   o_cpu_dat            read data returned to the CPU
//   i_mreq_n, i_iorq_n, i_rd_n, i_wr_n, i_m1_n
//                        CPU strobes, active low
//   o_wait_n             CPU wait, active low (combinational)
//   o_addr, o_dat, o_we  registered bus address, write data and write flag
//   i_dat                per-channel read data, channel c at [8c+7:8c]
//   o_cs, i_ack          one-hot chip select, per-channel acknowledge
//   o_err, i_err_clr     sticky timeout flag and its clear
module z80_bus_bridge #(
  parameter int         NCH         = 4,
  parameter int         IO_CH       = NCH - 1,
  parameter int         WS          = 0,
  parameter int         TIMEOUT     = 255,
  parameter logic [7:0] IACK_VECTOR = 8'hFF
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [15:0]      i_addr,
  input  logic [7:0]       i_cpu_dat,
  output logic [7:0]       o_cpu_dat,
  input  logic             i_mreq_n,
  input  logic             i_iorq_n,
  input  logic             i_rd_n,
  input  logic             i_wr_n,
  input  logic             i_m1_n,
  output logic             o_wait_n,
  output logic [15:0]      o_addr,
  output logic [7:0]       o_dat,
  input  logic [NCH*8-1:0] i_dat,
  output logic             o_we,
  output logic [NCH-1:0]   o_cs,
  input  logic [NCH-1:0]   i_ack,
  output logic             o_err,
  input  logic             i_err_clr
);

  localparam int          CHW    = $clog2(NCH);
  localparam logic [15:0] WS_LD  = 16'(WS);
  localparam logic [15:0] TMO_LD = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_e;

  state_e         state_q;
  logic [15:0]    cnt_q;
  logic [CHW-1:0] ch_q;
  logic [CHW-1:0] ch_d;

  logic       req;
  logic       iack;
  logic       active;
  logic       ack_sel;
  logic       timeout_hit;
  logic [7:0] dat_sel;

  function automatic logic [NCH-1:0] onehot(input logic [CHW-1:0] ch);
    onehot     = '0;
    onehot[ch] = 1'b1;
  endfunction

  assign req    = (~i_mreq_n | ~i_iorq_n) & (~i_rd_n | ~i_wr_n);
  assign iack   = ~i_m1_n & ~i_iorq_n;
  assign active = req | iack;

  // I/O cycles bypass the address decode and always land on IO_CH.
  assign ch_d = (!i_iorq_n) ? CHW'(IO_CH) : i_addr[15 -: CHW];

  // Only the selected channel's ack and data are visible.
  // Acks on other channels are ignored.
  always_comb begin
    dat_sel = 8'h00;
    ack_sel = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_q == CHW'(c)) begin
        dat_sel = i_dat[c*8 +: 8];
        ack_sel = i_ack[c];
      end
    end
  end

  // An ack in the same cycle as the last allowed cycle still completes normally.
  assign timeout_hit = (state_q == S_ACCESS) && active && !ack_sel && (cnt_q <= 16'd1);

  // Reset is gated in so that the wait output is released immediately,
  // even when the CPU strobes are still active during reset.
  assign o_wait_n = ~(i_reset_n & active & (state_q != S_DONE));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ch_q      <= '0;
      o_cs      <= '0;
      o_we      <= 1'b0;
      o_addr    <= '0;
      o_dat     <= '0;
      o_cpu_dat <= '0;
      o_err     <= 1'b0;
    end else begin
      // A timeout takes priority over a clear arriving in the same cycle.
      if (timeout_hit) begin
        o_err <= 1'b1;
      end else if (i_err_clr) begin
        o_err <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          o_cs <= '0;
          if (iack) begin
            o_cpu_dat <= IACK_VECTOR;
            state_q   <= S_DONE;
          end else if (req) begin
            state_q <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (!active) begin
            state_q <= S_IDLE;
          end else begin
            o_addr <= i_addr;
            o_dat  <= i_cpu_dat;
            o_we   <= ~i_wr_n;
            ch_q   <= ch_d;
            if (WS == 0) begin
              o_cs    <= onehot(ch_d);
              cnt_q   <= TMO_LD;
              state_q <= S_ACCESS;
            end else begin
              cnt_q   <= WS_LD;
              state_q <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (!active) begin
            o_cs    <= '0;
            state_q <= S_IDLE;
          end else if (cnt_q <= 16'd1) begin
            o_cs    <= onehot(ch_q);
            cnt_q   <= TMO_LD;
            state_q <= S_ACCESS;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end

        S_ACCESS: begin
          if (!active) begin
            o_cs    <= '0;
            state_q <= S_IDLE;
          end else if (ack_sel) begin
            // On a write, the read-data register keeps its old value.
            if (!o_we) begin
              o_cpu_dat <= dat_sel;
            end
            o_cs    <= '0;
            state_q <= S_DONE;
          end else if (timeout_hit) begin
            o_cpu_dat <= 8'hFF;
            o_cs      <= '0;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end

        S_DONE: begin
          o_cs <= '0;
          if (!active) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          o_cs    <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_bridge.sv
// tb_z80_bus_bridge
// Drives two bridge instances (WS=0 and WS=2, TIMEOUT=8) with directed and
// randomized CPU cycles. Expected behaviour comes from a cycle-count
// reference model: a cycle takes 2+WS+N wait cycles and N chip-select
// cycles, where N is the ack position or TIMEOUT.
module tb_z80_bus_bridge;

  localparam int         NCH = 4;
  localparam int         TMO = 8;
  localparam logic [7:0] VEC = 8'hFF;

  logic clk = 1'b0;
  logic rstN;

  logic [1:0][15:0] addr;
  logic [1:0][7:0]  cpuDat;
  logic [1:0]       mreqN, iorqN, rdN, wrN, m1N, errClr;
  logic [1:0][31:0] iDat;
  logic [1:0][3:0]  iAck;

  logic [1:0][7:0]  oCpuDat;
  logic [1:0]       waitN;
  logic [1:0][15:0] oAddr;
  logic [1:0][7:0]  oDat;
  logic [1:0]       oWe;
  logic [1:0][3:0]  oCs;
  logic [1:0]       oErr;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state, one entry per instance.
  logic [1:0]       mErr, mWe;
  logic [1:0][15:0] mAddr;
  logic [1:0][7:0]  mDat, mCpuDat;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gDut
    z80_bus_bridge #(
      .NCH(NCH), .IO_CH(NCH - 1), .WS(g == 0 ? 0 : 2), .TIMEOUT(TMO), .IACK_VECTOR(VEC)
    ) dut (
      .i_clk(clk), .i_reset_n(rstN),
      .i_addr(addr[g]), .i_cpu_dat(cpuDat[g]), .o_cpu_dat(oCpuDat[g]),
      .i_mreq_n(mreqN[g]), .i_iorq_n(iorqN[g]), .i_rd_n(rdN[g]), .i_wr_n(wrN[g]),
      .i_m1_n(m1N[g]), .o_wait_n(waitN[g]),
      .o_addr(oAddr[g]), .o_dat(oDat[g]), .i_dat(iDat[g]), .o_we(oWe[g]),
      .o_cs(oCs[g]), .i_ack(iAck[g]), .o_err(oErr[g]), .i_err_clr(errClr[g])
    );
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic releaseStrobes(input int inst);
    mreqN[inst] = 1'b1; iorqN[inst] = 1'b1; rdN[inst] = 1'b1;
    wrN[inst]   = 1'b1; m1N[inst]   = 1'b1;
  endtask

  task automatic resetModel();
    mErr = '0; mWe = '0; mAddr = '0; mDat = '0; mCpuDat = '0;
  endtask

  task automatic checkResetState(input int inst, input string tag);
    checkOutput({tag, "_wait"},   waitN[inst],   1);
    checkOutput({tag, "_cs"},     oCs[inst],     0);
    checkOutput({tag, "_we"},     oWe[inst],     0);
    checkOutput({tag, "_addr"},   oAddr[inst],   0);
    checkOutput({tag, "_dat"},    oDat[inst],    0);
    checkOutput({tag, "_cpuDat"}, oCpuDat[inst], 0);
    checkOutput({tag, "_err"},    oErr[inst],    0);
  endtask

  // Runs one complete CPU cycle on an instance.
  // Enter and return just after a posedge, with the bridge idle.
  // ackAt=0 means the target never acks. clrAt=-1 means no error clear.
  task automatic applyStimulus(input int inst, input bit iack, input bit isIo, input bit isWr,
                               input logic [15:0] a, input logic [7:0] wd, input logic [31:0] bus,
                               input int ackAt, input bit wrongAck, input int clrAt,
                               input string tag);
    int ws, ch, nAcc, expWait, ackCycle, waitLow, csHigh, csFirst;
    bit timedOut, oneHotOk, clrSeen;
    logic [3:0] csSeen, expCs;
    logic [7:0] rdData;
    ws       = (inst == 0) ? 0 : 2;
    ch       = isIo ? NCH - 1 : int'(a[15:14]);
    rdData   = bus[ch*8 +: 8];
    timedOut = !iack && (ackAt == 0);
    nAcc     = iack ? 0 : (timedOut ? TMO : ackAt);
    expWait  = iack ? 1 : 2 + ws + nAcc;
    ackCycle = (iack || timedOut) ? -1 : 1 + ws + ackAt;
    expCs    = '0;
    expCs[ch] = 1'b1;
    waitLow = 0; csHigh = 0; csFirst = -1; csSeen = '0; oneHotOk = 1'b1; clrSeen = 1'b0;

    addr[inst] = a; cpuDat[inst] = wd; iDat[inst] = bus;
    if (iack) begin
      m1N[inst] = 1'b0; iorqN[inst] = 1'b0; mreqN[inst] = 1'b1; rdN[inst] = 1'b1; wrN[inst] = 1'b1;
    end else begin
      m1N[inst] = 1'b1; mreqN[inst] = isIo; iorqN[inst] = !isIo; rdN[inst] = isWr; wrN[inst] = !isWr;
    end

    for (int k = 0; k < 100; k++) begin
      iAck[inst] = '0;
      if (k == ackCycle) iAck[inst][ch] = 1'b1;
      else if (wrongAck) iAck[inst][(ch + 1) % NCH] = 1'b1;
      errClr[inst] = (k == clrAt);
      @(negedge clk);
      if (waitN[inst]) break;
      waitLow++;
      if (errClr[inst]) clrSeen = 1'b1;
      if (oCs[inst] != '0) begin
        csHigh++;
        csSeen = oCs[inst];
        if (csFirst < 0) csFirst = k;
      end
      if ($countones(oCs[inst]) > 1) oneHotOk = 1'b0;
      @(posedge clk); #1;
    end
    iAck[inst]   = '0;
    errClr[inst] = 1'b0;

    if (iack) begin
      mCpuDat[inst] = VEC;
    end else begin
      mAddr[inst] = a; mDat[inst] = wd; mWe[inst] = isWr;
      if (timedOut) mCpuDat[inst] = 8'hFF;
      else if (!isWr) mCpuDat[inst] = rdData;
    end
    if (timedOut) mErr[inst] = 1'b1;
    else if (clrSeen) mErr[inst] = 1'b0;

    checkOutput({tag, "_waitCycles"}, waitLow, expWait);
    checkOutput({tag, "_csCycles"}, csHigh, nAcc);
    if (nAcc > 0) begin
      checkOutput({tag, "_csValue"}, csSeen, expCs);
      checkOutput({tag, "_csStart"}, csFirst, 2 + ws);
    end
    checkOutput({tag, "_oneHot"}, oneHotOk, 1);
    checkOutput({tag, "_csDone"}, oCs[inst], 0);
    checkOutput({tag, "_cpuDat"}, oCpuDat[inst], mCpuDat[inst]);
    checkOutput({tag, "_err"}, oErr[inst], mErr[inst]);
    checkOutput({tag, "_addr"}, oAddr[inst], mAddr[inst]);
    checkOutput({tag, "_dat"}, oDat[inst], mDat[inst]);
    checkOutput({tag, "_we"}, oWe[inst], mWe[inst]);

    @(posedge clk); #1;
    releaseStrobes(inst);
    @(negedge clk);
    checkOutput({tag, "_waitRelease"}, waitN[inst], 1);
    @(posedge clk); #1;
  endtask

  task automatic clearErr(input int inst, input string tag);
    errClr[inst] = 1'b1;
    @(posedge clk); #1;
    errClr[inst] = 1'b0;
    mErr[inst]   = 1'b0;
    @(negedge clk);
    checkOutput(tag, oErr[inst], mErr[inst]);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] csAny;
    int         inst;
    bit         iack;
    int         ackAt, clrAt;

    rstN = 1'b0;
    addr = '0; cpuDat = '0; iDat = '0; iAck = '0; errClr = '0;
    releaseStrobes(0); releaseStrobes(1);
    resetModel();
    #2;
    checkResetState(0, "reset0");
    checkResetState(1, "reset1");
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;

    // Minimum memory read: WS=0, ack on the first access cycle, channel 2.
    applyStimulus(0, 0, 0, 0, 16'h8123, 8'h00, 32'h005A_0000, 1, 0, -1, "minRead");
    checkOutput("minRead_data", oCpuDat[0], 8'h5A);

    // I/O write to port 0x0010 with two wait states, channel 3.
    applyStimulus(1, 0, 1, 1, 16'h0010, 8'h3C, $urandom, 2, 0, -1, "ioWrite");
    checkOutput("ioWrite_we", oWe[1], 1);
    checkOutput("ioWrite_dat", oDat[1], 8'h3C);

    // Timeout: no ack; the error stays set across a later good cycle until cleared.
    applyStimulus(0, 0, 0, 0, 16'h2000, 8'h00, $urandom, 0, 0, -1, "timeout");
    checkOutput("timeout_errSet", oErr[0], 1);
    applyStimulus(0, 0, 0, 0, 16'hC0DE, 8'h00, $urandom, 2, 0, -1, "afterTimeout");
    clearErr(0, "errClr_pulse");

    // Interrupt acknowledge is answered locally.
    applyStimulus(0, 1, 0, 0, 16'h0038, 8'h00, $urandom, 0, 0, -1, "iack");

    // Ack on channel 1 during a channel 0 access is ignored.
    applyStimulus(0, 0, 0, 0, 16'h1234, 8'h00, $urandom, 3, 1, -1, "wrongAck");

    // A timeout in the same cycle as a clear leaves the error set.
    applyStimulus(0, 0, 0, 1, 16'h3000, 8'h77, $urandom, 0, 0, 1 + TMO, "clrVsTimeout");
    applyStimulus(0, 0, 0, 0, 16'h4444, 8'h00, $urandom, 4, 0, 2, "clrMidAccess");

    // Strobes dropped while in WAIT: no chip select pulse.
    addr[1] = 16'hC000; cpuDat[1] = 8'hA5; mreqN[1] = 1'b0; rdN[1] = 1'b0;
    csAny = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); csAny |= oCs[1];
      @(posedge clk); #1;
    end
    releaseStrobes(1);
    @(negedge clk);
    checkOutput("abort_wait", waitN[1], 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); csAny |= oCs[1];
      @(posedge clk); #1;
    end
    mAddr[1] = 16'hC000; mDat[1] = 8'hA5; mWe[1] = 1'b0;
    checkOutput("abort_noCs", csAny, 0);
    checkOutput("abort_err", oErr[1], mErr[1]);
    checkOutput("abort_addr", oAddr[1], mAddr[1]);
    applyStimulus(1, 0, 0, 0, 16'hC001, 8'h00, $urandom, 1, 0, -1, "afterAbort");

    // Reset while channel 1 is being accessed.
    addr[0] = 16'h4000; mreqN[0] = 1'b0; rdN[0] = 1'b0; iDat[0] = $urandom;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rstMid_csBefore", oCs[0], 4'b0010);
    rstN = 1'b0;
    #1;
    resetModel();
    checkResetState(0, "rstMid");
    releaseStrobes(0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;

    // Randomized cycles on both instances.
    for (int n = 0; n < 40; n++) begin
      inst  = n % 2;
      iack  = ($urandom_range(0, 7) == 0);
      ackAt = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 5));
      clrAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      applyStimulus(inst, iack, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    16'($urandom), 8'($urandom), $urandom, ackAt,
                    1'($urandom_range(0, 1)), clrAt, "rand");
      if ($urandom_range(0, 3) == 0) clearErr(inst, "rand_errClr");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/z80_bus_bridge.md
# z80_bus_bridge

Parametrised bridge between Z80-style CPU bus strobes and a multi-channel acknowledge-based memory/peripheral bus. Decodes each CPU cycle to one of NCH chip-select channels, inserts programmable wait states, holds the CPU in wait until the selected target acknowledges or a timeout expires, and answers interrupt-acknowledge cycles locally with a fixed vector. It sits between the CPU core and the memories and peripherals in the computer top level.

## Interface

- NCH, 4: number of channels; power of two, 2..16. Memory space splits into NCH equal windows on the top log2(NCH) address bits.
- IO_CH, NCH-1: channel that receives all I/O cycles.
- WS, 0: wait states inserted before chip select, 0..15.
- TIMEOUT, 255: cycles chip select may stay asserted without ack, 1..65535.
- IACK_VECTOR, 8'hFF: byte returned on interrupt-acknowledge cycles.

- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_addr  in  16  CPU address
- i_cpu_dat  in  8  CPU write data
- o_cpu_dat  out  8  read data to CPU
- i_mreq_n, i_iorq_n, i_rd_n, i_wr_n, i_m1_n  in  1 each  CPU strobes, active low
- o_wait_n  out  1  CPU wait, active low
- o_addr  out  16  registered bus address
- o_dat  out  8  registered bus write data
- i_dat  in  NCH*8  per-channel read data, channel c at [8c+7:8c]
- o_we  out  1  write cycle
- o_cs  out  NCH  one-hot chip select
- i_ack  in  NCH  per-channel acknowledge
- o_err  out  1  sticky timeout flag
- i_err_clr  in  1  clears o_err

## Operation

- Request: (~i_mreq_n | ~i_iorq_n) & (~i_rd_n | ~i_wr_n). IACK: ~i_m1_n & ~i_iorq_n (no rd/wr required).
- States: IDLE, SETUP, WAIT, ACCESS, DONE.
- IDLE: on IACK -> DONE with o_cpu_dat <= IACK_VECTOR, no chip select. On request -> SETUP.
- SETUP (1 cycle): latch o_addr <= i_addr, o_dat <= i_cpu_dat, o_we <= ~i_wr_n; channel = IO_CH if iorq else i_addr[15 -: log2(NCH)]; load counter with WS. WS=0 -> ACCESS, else WAIT.
- WAIT: decrement counter; at 1 -> ACCESS.
- ACCESS: o_cs[ch] = 1, counter loaded with TIMEOUT on entry. Ack on i_ack[ch] (other channels' acks ignored): latch o_cpu_dat <= i_dat[ch] on reads (unchanged on writes), -> DONE. Counter reaching 0 without ack: o_cpu_dat <= 8'hFF, o_err <= 1, -> DONE.
- DONE: o_cs = 0. Stay until strobes release (request and IACK both false) -> IDLE.
- Abort: request/IACK dropping in SETUP, WAIT or ACCESS -> IDLE next cycle, o_cs cleared, o_err unchanged.
- o_wait_n combinational: 0 when (request | IACK) and state != DONE; else 1.
- o_err: i_err_clr clears; a timeout in the same cycle as i_err_clr wins (sets).

## Timing

- Reset (async, immediate): state IDLE, o_wait_n = 1, o_cs = 0, o_we = 0, o_addr = 0, o_dat = 0, o_cpu_dat = 0, o_err = 0, counters 0.
- Request sampled at edge 0 -> SETUP at edge 1 -> ACCESS at edge 2+WS.
- Ack sampled high at edge k in ACCESS -> DONE and data valid at edge k+1; o_wait_n high from then.
- Minimum access, WS=0 and ack in first ACCESS cycle: o_wait_n low 3 cycles.
- Timeout: o_cs high exactly TIMEOUT cycles, then DONE.
- o_addr/o_dat/o_we stable from SETUP until next SETUP; o_cs one-hot or zero at all times.
- Back-to-back cycles: new request needs one IDLE cycle after strobes release.

## Test plan

- Reset mid-ACCESS: i_reset_n low while o_cs=4'b0010 -> all outputs at reset values same cycle, o_wait_n = 1.
- Memory read, NCH=4, WS=0, addr 16'h8123, i_dat ch2 = 8'h5A, ack on first ACCESS cycle -> o_cs = 4'b0100 one cycle, o_cpu_dat = 8'h5A, o_wait_n low 3 cycles.
- I/O write 8'h3C to port 16'h0010, WS=2 -> o_cs[3] asserts 3 cycles after request seen, o_we = 1, o_dat = 8'h3C.
- Timeout: TIMEOUT=8, no ack -> o_cs high 8 cycles, o_cpu_dat = 8'hFF, o_err = 1 and stays 1 until i_err_clr pulse.
- IACK cycle (m1_n and iorq_n low) -> no o_cs, o_cpu_dat = 8'hFF (IACK_VECTOR), o_wait_n low exactly 1 cycle.
- Wrong-channel ack: i_ack[1] during ch0 access -> ignored; correct ack later completes; strobes dropped mid-WAIT -> IDLE, no o_cs pulse.
